// File: rtl/pcie_a7_4x_pipe_rate.sv
// PIPE rate-change sequencer: GT rate reprogram, PCLK 125/250 MHz switch, one PHYSTATUS pulse to the core.
// Latency: 2 sync + 6 FSM cycles + PCIE_SETTLE_CYCLES minimum; waits are bounded by PCIE_TIMEOUT_CYCLES.
module pcie_a7_4x_pipe_rate #(
    parameter int PCIE_LANE           = 4,
    parameter int PCIE_LINK_SPEED     = 2,
    parameter int PCIE_SETTLE_CYCLES  = 64,
    parameter int PCIE_TIMEOUT_CYCLES = 4096
) (
    input  logic                 RATE_CLK,
    input  logic                 RATE_RST_N,
    input  logic                 RATE_MMCM_LOCK,
    input  logic [1:0]           RATE_RATE_IN,
    input  logic [PCIE_LANE-1:0] RATE_TXRATEDONE,
    input  logic [PCIE_LANE-1:0] RATE_RXRATEDONE,
    input  logic [PCIE_LANE-1:0] RATE_PHYSTATUS,
    output logic [PCIE_LANE-1:0] RATE_PCLK_SEL,
    output logic [2:0]           RATE_RATE_OUT,
    output logic                 RATE_PHYSTATUS_OUT,
    output logic                 RATE_IDLE,
    output logic                 RATE_TIMEOUT,
    output logic [3:0]           RATE_FSM
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_LOCK_WAIT = 4'd1;
    localparam logic [3:0] ST_RATE_SET  = 4'd2;
    localparam logic [3:0] ST_DONE_WAIT = 4'd3;
    localparam logic [3:0] ST_PCLK_SW   = 4'd4;
    localparam logic [3:0] ST_SETTLE    = 4'd5;
    localparam logic [3:0] ST_PHY_WAIT  = 4'd6;
    localparam logic [3:0] ST_DONE      = 4'd7;

    localparam int TW = $clog2(PCIE_TIMEOUT_CYCLES) + 1;
    localparam int SW = $clog2(PCIE_SETTLE_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST     = TW'(PCIE_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(PCIE_SETTLE_CYCLES - 1);

    logic [3:0]           r_state;
    logic [1:0]           r_rate_q1;
    logic [1:0]           r_rate_q2;
    logic                 r_cur_rate;
    logic                 r_tgt;
    logic                 r_rate_out;
    logic [PCIE_LANE-1:0] r_tx_mask;
    logic [PCIE_LANE-1:0] r_rx_mask;
    logic [PCIE_LANE-1:0] r_phy_mask;
    logic [PCIE_LANE-1:0] r_pclk_sel;
    logic [TW-1:0]        r_to_cnt;
    logic [SW-1:0]        r_settle_cnt;
    logic                 r_timeout;

    logic                 w_target;
    logic                 w_lock_lost;
    logic                 w_to_hit;
    logic [PCIE_LANE-1:0] w_tx_mask;
    logic [PCIE_LANE-1:0] w_rx_mask;
    logic [PCIE_LANE-1:0] w_phy_mask;

    // Gen3 and above are not supported by the GT here, so any non-zero request means Gen2.
    assign w_target    = (r_rate_q2 != 2'd0) && (PCIE_LINK_SPEED >= 2);
    assign w_lock_lost = !RATE_MMCM_LOCK && (r_state != ST_IDLE) && (r_state != ST_LOCK_WAIT);
    assign w_to_hit    = (r_to_cnt == TO_LAST);
    assign w_tx_mask   = r_tx_mask  | RATE_TXRATEDONE;
    assign w_rx_mask   = r_rx_mask  | RATE_RXRATEDONE;
    assign w_phy_mask  = r_phy_mask | RATE_PHYSTATUS;

    always_ff @(posedge RATE_CLK or negedge RATE_RST_N) begin
        if (!RATE_RST_N) begin
            r_state      <= ST_IDLE;
            r_rate_q1    <= '0;
            r_rate_q2    <= '0;
            r_cur_rate   <= 1'b0;
            r_tgt        <= 1'b0;
            r_rate_out   <= 1'b0;
            r_tx_mask    <= '0;
            r_rx_mask    <= '0;
            r_phy_mask   <= '0;
            r_pclk_sel   <= '0;
            r_to_cnt     <= '0;
            r_settle_cnt <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_rate_q1 <= RATE_RATE_IN;
            r_rate_q2 <= r_rate_q1;
            // Losing the MMCM mid-sequence restarts from RATE_SET once the clock is back.
            if (w_lock_lost) begin
                r_state <= ST_LOCK_WAIT;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_target != r_cur_rate)
                            r_state <= RATE_MMCM_LOCK ? ST_RATE_SET : ST_LOCK_WAIT;
                    end
                    ST_LOCK_WAIT: begin
                        if (RATE_MMCM_LOCK)
                            r_state <= ST_RATE_SET;
                    end
                    ST_RATE_SET: begin
                        r_tgt      <= w_target;
                        r_rate_out <= w_target;
                        r_tx_mask  <= '0;
                        r_rx_mask  <= '0;
                        r_to_cnt   <= '0;
                        r_state    <= ST_DONE_WAIT;
                    end
                    ST_DONE_WAIT: begin
                        r_tx_mask <= w_tx_mask;
                        r_rx_mask <= w_rx_mask;
                        if ((&w_tx_mask) && (&w_rx_mask)) begin
                            r_state <= ST_PCLK_SW;
                        end else if (w_to_hit) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_PCLK_SW;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                    ST_PCLK_SW: begin
                        r_pclk_sel   <= {PCIE_LANE{r_tgt}};
                        r_settle_cnt <= SETTLE_LOAD;
                        r_state      <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (r_settle_cnt == '0) begin
                            r_phy_mask <= '0;
                            r_to_cnt   <= '0;
                            r_state    <= ST_PHY_WAIT;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - 1'b1;
                        end
                    end
                    ST_PHY_WAIT: begin
                        r_phy_mask <= w_phy_mask;
                        if (&w_phy_mask) begin
                            r_state <= ST_DONE;
                        end else if (w_to_hit) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_cur_rate <= r_tgt;
                        r_state    <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign RATE_PCLK_SEL      = r_pclk_sel;
    assign RATE_RATE_OUT      = {2'b00, r_rate_out};
    assign RATE_PHYSTATUS_OUT = (r_state == ST_DONE);
    assign RATE_IDLE          = (r_state == ST_IDLE);
    assign RATE_TIMEOUT       = r_timeout;
    assign RATE_FSM           = r_state;

endmodule

// File: tb/tb_pcie_a7_4x_pipe_rate.sv
// Bench for pcie_a7_4x_pipe_rate: transaction-level timeline model with a per-cycle output compare.
module tb_pcie_a7_4x_pipe_rate;

    localparam int SETTLE = 64;
    localparam int TMO    = 4096;
    localparam int BIG    = 1 << 30;
    localparam int M_RAND = 0;
    localparam int M_STAG = 1;
    localparam int M_TMO  = 2;
    localparam int M_LOCK = 3;
    localparam int M_RST  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock = 1'b1;
    logic [1:0] rate_in = 2'd0;
    logic [3:0] txdone = '0;
    logic [3:0] rxdone = '0;
    logic [3:0] phy = '0;

    logic [3:0] o_pclk, o1_pclk;
    logic [2:0] o_rate, o1_rate;
    logic       o_pulse, o1_pulse, o_idle, o1_idle, o_to, o1_to;
    logic [3:0] o_fsm, o1_fsm;

    pcie_a7_4x_pipe_rate #(
        .PCIE_LANE(4), .PCIE_LINK_SPEED(2),
        .PCIE_SETTLE_CYCLES(SETTLE), .PCIE_TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .RATE_CLK(clk), .RATE_RST_N(rst_n), .RATE_MMCM_LOCK(lock),
        .RATE_RATE_IN(rate_in), .RATE_TXRATEDONE(txdone), .RATE_RXRATEDONE(rxdone),
        .RATE_PHYSTATUS(phy), .RATE_PCLK_SEL(o_pclk), .RATE_RATE_OUT(o_rate),
        .RATE_PHYSTATUS_OUT(o_pulse), .RATE_IDLE(o_idle), .RATE_TIMEOUT(o_to),
        .RATE_FSM(o_fsm)
    );

    pcie_a7_4x_pipe_rate #(
        .PCIE_LANE(4), .PCIE_LINK_SPEED(1),
        .PCIE_SETTLE_CYCLES(SETTLE), .PCIE_TIMEOUT_CYCLES(TMO)
    ) u_dut_gen1 (
        .RATE_CLK(clk), .RATE_RST_N(rst_n), .RATE_MMCM_LOCK(lock),
        .RATE_RATE_IN(rate_in), .RATE_TXRATEDONE(txdone), .RATE_RXRATEDONE(rxdone),
        .RATE_PHYSTATUS(phy), .RATE_PCLK_SEL(o1_pclk), .RATE_RATE_OUT(o1_rate),
        .RATE_PHYSTATUS_OUT(o1_pulse), .RATE_IDLE(o1_idle), .RATE_TIMEOUT(o1_to),
        .RATE_FSM(o1_fsm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model: each output is an old value until a predicted change cycle, then the new value.
    int m_cur = 0;
    int m_rate_old = 0, m_rate_new = 0, m_rate_at = 0;
    int m_pclk_old = 0, m_pclk_new = 0, m_pclk_at = 0;
    int m_to_at = BIG;
    int m_pulse_at = -1;
    int m_busy_from = BIG, m_idle_at = 0;
    int m_lw_from = BIG, m_lw_to = BIG - 1;

    int obs_pulses = 0, obs_pulse_cyc = 0, obs_pclk_chg = 0, last_k = 0;
    logic [3:0] prev_pclk = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = 0;
        m_rate_old = 0; m_rate_new = 0; m_rate_at = 0;
        m_pclk_old = 0; m_pclk_new = 0; m_pclk_at = 0;
        m_to_at = BIG; m_pulse_at = -1;
        m_busy_from = BIG; m_idle_at = 0;
        m_lw_from = BIG; m_lw_to = BIG - 1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rate_out", 32'(o_rate), (cyc >= m_rate_at) ? m_rate_new : m_rate_old);
            chk("pclk_sel", 32'(o_pclk), ((cyc >= m_pclk_at) ? m_pclk_new : m_pclk_old) * 15);
            chk("phystatus_out", 32'(o_pulse), (cyc == m_pulse_at) ? 1 : 0);
            chk("timeout", 32'(o_to), (cyc >= m_to_at) ? 1 : 0);
            chk("idle", 32'(o_idle), (cyc < m_busy_from || cyc >= m_idle_at) ? 1 : 0);
            if (cyc < m_busy_from || cyc >= m_idle_at) chk("fsm_idle", 32'(o_fsm), 0);
            if (cyc >= m_lw_from && cyc <= m_lw_to) chk("fsm_lock_wait", 32'(o_fsm), 1);
            if (cyc == m_lw_to + 1) chk("fsm_relock_rate_set", 32'(o_fsm), 2);
            chk("gen1_pclk_sel", 32'(o1_pclk), 0);
            chk("gen1_rate_out", 32'(o1_rate), 0);
            chk("gen1_pulse", 32'(o1_pulse), 0);
            chk("gen1_idle", 32'(o1_idle), 1);
            chk("gen1_fsm", 32'(o1_fsm), 0);
            if (o_pulse) begin obs_pulses++; obs_pulse_cyc = cyc; end
            if (o_pclk != prev_pclk) obs_pclk_chg = cyc;
        end
        prev_pclk = o_pclk;
    end

    task automatic do_seq(input logic [1:0] rin, input int mode);
        int k, t, rs, dw, d, s, p, lw_l, stop_c, p0;
        int txa [4];
        int rxa [4];
        int pa [4];
        bit aborted;
        @(negedge clk);
        k = cyc; last_k = k; rate_in = rin; aborted = 1'b0;
        t = (rin != 2'd0) ? 1 : 0;
        p0 = obs_pulses;
        if (t == m_cur) begin
            repeat (40) @(negedge clk);
            chk("same_rate_no_pulse", 32'(obs_pulses - p0), 0);
            return;
        end
        rs = k + 3;
        lw_l = BIG;
        if (mode == M_LOCK) begin
            lw_l = rs + 3;
            rs = lw_l + 21;
        end
        dw = rs + 1;
        d = dw;
        for (int i = 0; i < 4; i++) begin
            if (mode == M_STAG) begin
                txa[i] = dw + 3 + 2 * i;
                rxa[i] = txa[i];
            end else begin
                txa[i] = dw + int'($urandom_range(0, 8));
                rxa[i] = dw + int'($urandom_range(0, 8));
            end
            if (txa[i] > d) d = txa[i];
            if (rxa[i] > d) d = rxa[i];
        end
        if (mode == M_TMO) begin
            rxa[2] = BIG;
            d = dw + TMO - 1;
        end
        s = d + 2 + SETTLE;
        p = s;
        for (int i = 0; i < 4; i++) begin
            pa[i] = s + ((mode == M_STAG) ? 2 : int'($urandom_range(0, 5)));
            if (pa[i] > p) p = pa[i];
        end
        m_rate_old = m_rate_new; m_rate_new = t; m_rate_at = k + 4;
        m_pclk_old = m_pclk_new; m_pclk_new = t; m_pclk_at = d + 2;
        if (mode == M_TMO && m_to_at == BIG) m_to_at = d + 1;
        m_pulse_at = p + 1;
        m_busy_from = k + 3;
        m_idle_at = p + 2;
        if (mode == M_LOCK) begin
            m_lw_from = lw_l + 1;
            m_lw_to = lw_l + 20;
        end
        m_cur = t;
        stop_c = p + 6;
        for (int c = k + 1; c <= stop_c; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                txdone[i] = (c == txa[i]);
                rxdone[i] = (c == rxa[i]);
                phy[i]    = (c == pa[i]);
                // Stray pulses outside the state that listens for them must be ignored.
                if (mode == M_RAND) begin
                    if (c < dw || c > d) begin
                        txdone[i] = txdone[i] | ($urandom_range(0, 3) == 0);
                        rxdone[i] = rxdone[i] | ($urandom_range(0, 3) == 0);
                    end
                    if (c < s) phy[i] = phy[i] | ($urandom_range(0, 3) == 0);
                end
            end
            lock = !(c >= lw_l && c < lw_l + 20);
            if (mode == M_RST && c == d + 5) begin
                aborted = 1'b1;
                break;
            end
        end
        txdone = '0; rxdone = '0; phy = '0; lock = 1'b1;
        if (aborted) begin
            #2;
            chk_en = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("async_rst_pclk_sel", 32'(o_pclk), 0);
            chk("async_rst_rate_out", 32'(o_rate), 0);
            chk("async_rst_pulse", 32'(o_pulse), 0);
            chk("async_rst_idle", 32'(o_idle), 1);
            chk("async_rst_timeout", 32'(o_to), 0);
            chk("async_rst_fsm", 32'(o_fsm), 0);
            model_reset();
            rate_in = 2'd0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            chk_en = 1'b1;
        end else begin
            chk("one_pulse_per_change", 32'(obs_pulses - p0), 1);
        end
    endtask

    initial begin
        int p0;
        repeat (3) @(negedge clk);
        chk("reset_pclk_sel", 32'(o_pclk), 0);
        chk("reset_rate_out", 32'(o_rate), 0);
        chk("reset_pulse", 32'(o_pulse), 0);
        chk("reset_idle", 32'(o_idle), 1);
        chk("reset_timeout", 32'(o_to), 0);
        chk("reset_fsm", 32'(o_fsm), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        p0 = obs_pulses;
        repeat (100) @(negedge clk);
        chk("idle_100_no_pulse", 32'(obs_pulses - p0), 0);

        do_seq(2'd1, M_STAG);
        chk("gen2_latency", 32'(obs_pulse_cyc - last_k), 82);
        chk("gen2_rate_out", 32'(o_rate), 1);
        chk("gen2_pclk_sel", 32'(o_pclk), 15);
        chk("gen2_timeout", 32'(o_to), 0);

        do_seq(2'd0, M_STAG);
        chk("gen1_settle_gap", 32'(obs_pulse_cyc - obs_pclk_chg), 67);
        chk("gen1_pclk_sel", 32'(o_pclk), 0);
        chk("gen1_rate_out", 32'(o_rate), 0);

        do_seq(2'd0, M_RAND);
        do_seq(2'd3, M_RAND);
        do_seq(2'd2, M_RAND);
        for (int n = 0; n < 8; n++) do_seq(2'($urandom_range(0, 3)), M_RAND);

        do_seq((m_cur != 0) ? 2'd0 : 2'd1, M_TMO);
        chk("tmo_done_wait_len", 32'(obs_pclk_chg - last_k), 4101);
        chk("tmo_sticky", 32'(o_to), 1);

        do_seq((m_cur != 0) ? 2'd0 : 2'd1, M_LOCK);
        do_seq((m_cur != 0) ? 2'd0 : 2'd2, M_RAND);

        if (m_cur != 0) do_seq(2'd0, M_RAND);
        do_seq(2'd1, M_RST);

        p0 = obs_pulses;
        repeat (20) @(negedge clk);
        chk("post_reset_no_pulse", 32'(obs_pulses - p0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/pcie_a7_4x_pipe_rate.md
Name: pcie_a7_4x_pipe_rate

Overview:
- Per-link PIPE rate-change sequencer for the Artix-7 x4 PCIe PIPE wrapper.
- Consumes the pipe clock block's MMCM lock output and drives that block's per-lane PCLK select inputs.
- Takes the core's requested rate, reprograms the GT rate, switches PCLK between 125 and 250 MHz, and returns a single PHYSTATUS completion pulse to the core.

Parameters:
- PCIE_LANE, 4, number of lanes; sets vector widths.
- PCIE_LINK_SPEED, 2, max supported generation; 1 forces every request to Gen1.
- PCIE_SETTLE_CYCLES, 64, wait cycles after a PCLK_SEL change before phystatus is sampled; must be >= 1.
- PCIE_TIMEOUT_CYCLES, 4096, cycle limit for each wait state before a forced advance.

Ports:
- RATE_CLK  input  1  PCLK domain clock.
- RATE_RST_N  input  1  asynchronous active-low reset.
- RATE_MMCM_LOCK  input  1  MMCM lock from the pipe clock block.
- RATE_RATE_IN  input  2  core requested rate: 0 Gen1, 1 Gen2, 2/3 treated as Gen2.
- RATE_TXRATEDONE  input  PCIE_LANE  per-lane GT TX rate-done pulse.
- RATE_RXRATEDONE  input  PCIE_LANE  per-lane GT RX rate-done pulse.
- RATE_PHYSTATUS  input  PCIE_LANE  per-lane GT phystatus pulse.
- RATE_PCLK_SEL  output  PCIE_LANE  to the pipe clock block's CLK_PCLK_SEL; 1 = 250 MHz.
- RATE_RATE_OUT  output  3  GT TXRATE/RXRATE code: 000 Gen1, 001 Gen2.
- RATE_PHYSTATUS_OUT  output  1  one-cycle completion pulse to the core.
- RATE_IDLE  output  1  high when the FSM is in IDLE.
- RATE_TIMEOUT  output  1  sticky; set when any wait state times out.
- RATE_FSM  output  4  state encoding, for debug.

Behaviour:
- Reset value of every output:
  - RATE_PCLK_SEL = 0.
  - RATE_RATE_OUT = 000.
  - RATE_PHYSTATUS_OUT = 0.
  - RATE_IDLE = 1.
  - RATE_TIMEOUT = 0.
  - RATE_FSM = 0 (IDLE).
  - Internal cur_rate = 0; both sticky masks and all counters = 0.
- Input registration: RATE_RATE_IN passes through two registers (rate_q1, rate_q2).
- Target clamping: target = (rate_q2 != 0 && PCIE_LINK_SPEED >= 2) ? Gen2 : Gen1.
- FSM states (encoding 0..7): IDLE, LOCK_WAIT, RATE_SET, DONE_WAIT, PCLK_SW, SETTLE, PHY_WAIT, DONE.
- IDLE: when target != cur_rate, go to RATE_SET if RATE_MMCM_LOCK is high, otherwise LOCK_WAIT.
- LOCK_WAIT: stay until RATE_MMCM_LOCK is high, then go to RATE_SET.
- RATE_SET (1 cycle):
  - Latch target into tgt_reg.
  - Drive RATE_RATE_OUT = tgt_reg.
  - Clear tx_mask, rx_mask and the timeout counter.
  - Go to DONE_WAIT.
- DONE_WAIT:
  - tx_mask |= RATE_TXRATEDONE; rx_mask |= RATE_RXRATEDONE. Inputs are OR'd into the masks in the same cycle they are checked.
  - Go to PCLK_SW when both masks are all-ones, or when the counter reaches PCIE_TIMEOUT_CYCLES-1. A timeout also sets RATE_TIMEOUT.
- PCLK_SW (1 cycle):
  - RATE_PCLK_SEL = {PCIE_LANE{tgt_reg == Gen2}}.
  - Load the settle counter; go to SETTLE.
- SETTLE: wait exactly PCIE_SETTLE_CYCLES cycles, then go to PHY_WAIT with the phy mask and timeout counter cleared.
- PHY_WAIT:
  - phy_mask |= RATE_PHYSTATUS.
  - Go to DONE when the mask is all-ones or on timeout. A timeout also sets RATE_TIMEOUT.
- DONE (1 cycle): RATE_PHYSTATUS_OUT = 1, cur_rate = tgt_reg, go to IDLE.
- Latency: minimum request-to-pulse with all GT responses immediate is 2 (sync) + 1 (IDLE) + 1 (RATE_SET) + 1 (DONE_WAIT) + 1 (PCLK_SW) + PCIE_SETTLE_CYCLES + 1 (PHY_WAIT) + 1 (DONE) cycles.
- Lock loss: RATE_MMCM_LOCK low in any state other than IDLE or LOCK_WAIT forces LOCK_WAIT.
  - Outputs hold their values.
  - When lock returns, the sequence restarts at RATE_SET with the current target.
- New request mid-sequence: RATE_RATE_IN changes are ignored after RATE_SET. If target still differs from cur_rate after DONE, IDLE starts a new sequence.
- Same-rate request: no activity and no pulse.
- Timeout counter saturates and is cleared on every wait-state entry. RATE_TIMEOUT clears only on reset.
- Simultaneous lane pulses in the same cycle are all captured. Pulses in non-wait states are ignored.

Test Plan:
- Reset, lock=1, RATE_RATE_IN=0 -> outputs stay at reset values, RATE_IDLE=1, no pulse over 100 cycles.
- Lock=1, RATE_RATE_IN 0->1; lanes 0..3 return tx/rx ratedone at staggered delays 3/5/7/9; phystatus 2 cycles after PCLK settle -> RATE_RATE_OUT=001, RATE_PCLK_SEL=1111 after the last ratedone, exactly one RATE_PHYSTATUS_OUT pulse, RATE_TIMEOUT=0.
- Same Gen2->Gen1 with PCIE_SETTLE_CYCLES=64 -> RATE_PCLK_SEL=0000; pulse no earlier than 64 cycles after the PCLK_SEL change.
- Lane 2 never asserts RXRATEDONE, PCIE_TIMEOUT_CYCLES=4096 -> FSM advances after 4096 cycles in DONE_WAIT, RATE_TIMEOUT=1, pulse still issued.
- Drop RATE_MMCM_LOCK for 20 cycles during DONE_WAIT -> RATE_FSM=LOCK_WAIT while lock is low; after relock RATE_SET is re-entered and the sequence completes with a single pulse.
- PCIE_LINK_SPEED=1, RATE_RATE_IN=1 -> no state change, RATE_RATE_OUT=000, no pulse; assert RATE_RST_N low mid-sequence -> all outputs return to reset values immediately (asynchronously).
